// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative one-bit-per-cycle multiply/divide unit with tag passthrough
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             div0_o,
    output logic             illegal_o,
    output logic             busy_o,
    input  logic             flush_i
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] F_MUL   = 3'd0;
    localparam logic [2:0] F_MULH  = 3'd1;
    localparam logic [2:0] F_MULHU = 3'd2;
    localparam logic [2:0] F_DIV   = 3'd3;
    localparam logic [2:0] F_DIVU  = 3'd4;
    localparam logic [2:0] F_MOD   = 3'd5;
    localparam logic [2:0] F_MODU  = 3'd6;
    localparam logic [2:0] F_ILL   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             func_q, func_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   div0_q, div0_d;
    logic                   illegal_q, illegal_d;

    logic                   req_signed, req_is_mul, req_is_div;
    logic [WIDTH-1:0]       mag_a, mag_b;

    // prod_q is {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         div_part;
    logic [WIDTH+1:0]       div_diff;
    logic                   div_fits;
    logic [2*WIDTH-1:0]     div_next;
    logic [2*WIDTH-1:0]     step_next;
    logic [2*WIDTH-1:0]     prod_signed;
    logic [WIDTH-1:0]       quo_signed, rem_signed;
    logic [WIDTH-1:0]       final_result;
    logic                   is_mul_q;

    assign req_signed = (func_i == F_MULH) || (func_i == F_DIV) || (func_i == F_MOD);
    assign req_is_mul = (func_i == F_MUL) || (func_i == F_MULH) || (func_i == F_MULHU);
    assign req_is_div = (func_i == F_DIV) || (func_i == F_DIVU) || (func_i == F_MOD) || (func_i == F_MODU);
    assign mag_a      = (req_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b      = (req_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    assign is_mul_q   = (func_q == F_MUL) || (func_q == F_MULH) || (func_q == F_MULHU);

    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Partial remainder is always below twice the divisor, so bit WIDTH of a non-borrowing difference is zero
    assign div_part = prod_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = {1'b0, div_part} - {2'b00, opnd_q};
    assign div_fits = ~|div_diff[WIDTH+1:WIDTH];
    assign div_next = div_fits ? {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                               : {prod_q[2*WIDTH-2:0], 1'b0};

    assign step_next   = is_mul_q ? mul_next : div_next;
    assign prod_signed = (sign_a_q ^ sign_b_q) ? -step_next : step_next;
    assign quo_signed  = (sign_a_q ^ sign_b_q) ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    assign rem_signed  = sign_a_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];

    always_comb begin
        final_result = '0;
        case (func_q)
            F_MUL:           final_result = prod_signed[WIDTH-1:0];
            F_MULH, F_MULHU: final_result = prod_signed[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:   final_result = quo_signed;
            F_MOD, F_MODU:   final_result = rem_signed;
            default:         final_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        func_d    = func_q;
        tag_d     = tag_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        result_d  = result_q;
        div0_d    = div0_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    func_d   = func_i;
                    tag_d    = tag_i;
                    sign_a_d = req_signed & a_i[WIDTH-1];
                    sign_b_d = req_signed & b_i[WIDTH-1];
                    opnd_d   = req_is_mul ? mag_a : mag_b;
                    prod_d   = {{WIDTH{1'b0}}, (req_is_mul ? mag_b : mag_a)};
                    cnt_d    = CW'(WIDTH - 1);
                    if (func_i == F_ILL) begin
                        state_d   = S_DONE;
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end else if (req_is_div && (b_i == '0)) begin
                        state_d  = S_DONE;
                        result_d = ((func_i == F_DIV) || (func_i == F_DIVU)) ? '1 : a_i;
                        div0_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                prod_d = step_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = final_result;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d   = S_IDLE;
                    div0_d    = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d   = S_IDLE;
            div0_d    = 1'b0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            func_q    <= '0;
            tag_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            opnd_q    <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            func_q    <= func_d;
            tag_q     <= tag_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            div0_q    <= div0_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;
    assign tag_o       = tag_q;
    assign div0_o      = div0_q;
    assign illegal_o   = illegal_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised iterative multiply/divide unit for the bexkat1 execute stage.
- Replaces the fixed 4-cycle delay counter that stalls the pipeline for T_INT/T_INTU ops.
- Computes one bit per cycle, so latency tracks WIDTH; uses valid/ready handshakes, carries a writeback tag, and can be flushed.
- Reports divide-by-zero and illegal-function conditions to the exception logic.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- TAG_W, 4, width of the destination-register tag passed through with the result.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset
- in_valid_i  input  1  operation request
- in_ready_o  output  1  unit can accept a request
- func_i  input  3  0 MUL (low word), 1 MULH signed, 2 MULHU, 3 DIV signed, 4 DIVU, 5 MOD signed, 6 MODU, 7 illegal
- a_i  input  WIDTH  dividend / multiplicand
- b_i  input  WIDTH  divisor / multiplier
- tag_i  input  TAG_W  destination register tag
- out_valid_o  output  1  result available
- out_ready_i  input  1  consumer accepts result
- result_o  output  WIDTH  result
- tag_o  output  TAG_W  tag captured with the operation
- div0_o  output  1  result came from a divide/mod by zero (qualified by out_valid_o)
- illegal_o  output  1  func_i was 7 (qualified by out_valid_o)
- busy_o  output  1  state != IDLE; drives execute-stage stall
- flush_i  input  1  abort any operation in flight

Behaviour:
- Reset: rst_i is asynchronous, active-high; clk_i is the clock.
  - Outputs at reset: state IDLE; in_ready_o=1; out_valid_o=0; result_o=0; tag_o=0; div0_o=0; illegal_o=0; busy_o=0; internal counter and accumulators 0.
- States: IDLE, CALC, DONE.
- in_ready_o is 1 only in IDLE. A request is accepted on an edge where in_valid_i && in_ready_o && !flush_i. On acceptance, func_i, tag_i, operand signs and operand magnitudes are latched.
  - Magnitude is two's-complement absolute value for signed funcs (1, 3, 5); raw value otherwise.
- IDLE -> CALC on acceptance, with the counter loaded to WIDTH-1.
- Fast paths, IDLE -> DONE directly (out_valid_o high on the edge after acceptance):
  - func 7: result 0, illegal_o=1.
  - func 3-6 with b_i==0: DIV/DIVU give all-ones; MOD/MODU give a_i unmodified; div0_o=1.
- Multiply: shift-add over a 2*WIDTH-bit product, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle, WIDTH-bit remainder plus a borrow bit.
- CALC -> DONE when the counter is 0, so out_valid_o rises WIDTH+1 edges after acceptance.
- Result selection and sign fix, registered on entry to DONE:
  - MUL: low WIDTH bits of the product, negated if the operand signs differ. The low word is sign-agnostic, so this equals the unsigned low word.
  - MULH: high WIDTH bits of the signed 2*WIDTH-bit product.
  - MULHU: high WIDTH bits of the unsigned product.
  - DIV: quotient, negated if the signs differ.
  - MOD: remainder, carrying the sign of the dividend.
  - DIVU/MODU: unsigned quotient/remainder.
- Signed overflow (MIN / -1) needs no special case: quotient = MIN, remainder = 0, div0_o=0.
- DONE: result_o, tag_o, div0_o and illegal_o are held stable while out_valid_o=1 && !out_ready_i.
  - DONE -> IDLE on an edge with out_ready_i=1; out_valid_o falls that edge and div0_o/illegal_o clear.
  - No back-to-back acceptance in the same edge as the result handoff; the next request is accepted no earlier than the following edge.
- flush_i: from any state, the next edge goes to IDLE, drops out_valid_o, clears div0_o/illegal_o, and discards the result. A request presented with flush_i high is not accepted. flush_i takes priority over out_ready_i.
- rst_i asserted mid-CALC or in DONE returns everything to the reset values immediately, without waiting for a clock edge.
- Changes to a_i/b_i/func_i/tag_i after acceptance have no effect on the operation in flight.

Test Plan:
- WIDTH=32: MUL a=7, b=6 -> out_valid_o rises exactly 33 edges after acceptance, result 42, tag echoed, div0_o=0.
- MULH a=0xFFFFFFFF (-1), b=2 -> 0xFFFFFFFF; MULHU with the same operands -> 0x00000001; MUL -> 0xFFFFFFFE.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3); MOD -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14; MODU -> 2.
- DIVU a=5, b=0 -> out_valid_o on the next edge, result 0xFFFFFFFF, div0_o=1; MOD a=5, b=0 -> 5, div0_o=1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, div0_o=0.
- Hold out_ready_i=0 for 10 cycles in DONE -> result, tag and out_valid_o stable and in_ready_o=0. Then pulse out_ready_i -> IDLE, in_ready_o=1 on the next edge.
- flush_i at CALC cycle 10 -> IDLE next edge, no out_valid_o pulse, new op accepted and correct. Async rst_i mid-CALC -> all outputs at reset values before the next edge. func_i=7 -> illegal_o=1 one edge after acceptance.
